calc_sequencer: RTL

- Downstream of the keypad input stage, which delivers the two's-complement operand, its range-valid flag and the "load" enter key.
- Captures operand A, then operand B plus an operator, and executes add, sub or multiply. Multiply is an iterative 8-cycle unit.
- Holds a signed 16-bit result for the display/BCD conversion stage.
- Pulses a clear request so the input stage shift registers restart for the next entry.

---
 rtl/calc_sequencer_pkg.sv | 57 +++++
 rtl/calc_sequencer_if.sv | 31 +++
 rtl/calc_sequencer_muldiv.sv | 164 ++++++++++++++++
 rtl/calc_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg : shared types and constants for the calculator sequencer.
//   - state_e : sequencer FSM states (WAIT_A..ERROR, codes 0..4)
//   - op_e    : operator codes (ADD=0, SUB=1, MUL=2, DIV=3)
//   - W / RW  : operand / result widths, ITER : iterative unit cycle count
//   - mag / sext / apply_sign : two's-complement helper functions
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int W     = 8;
    localparam int RW    = 16;
    localparam int ITER  = 8;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        ST_WAIT_A = 3'd0,
        ST_WAIT_B = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    // Unsigned magnitude of a two's-complement operand; -128 maps to 128.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        logic [W-1:0] m;
        if (x[W-1]) begin
            m = ~x + {{(W-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Sign-extend an operand to result width.
    function automatic logic [RW-1:0] sext(input logic [W-1:0] x);
        return {{(RW-W){x[W-1]}}, x};
    endfunction

    // Re-apply a sign to an unsigned magnitude result.
    function automatic logic [RW-1:0] apply_sign(input logic neg, input logic [RW-1:0] m);
        logic [RW-1:0] r;
        if (neg) begin
            r = ~m + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            r = m;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_sequencer_if : bus between the keypad input stage and the sequencer.
//   input-stage side : enter, operand, operand_ok, op
//   sequencer side   : result, done, error, busy, clr_entry, state
// modport master = input stage / environment, modport slave = calc_sequencer.
// -----------------------------------------------------------------------------
interface calc_sequencer_if;
    import calc_pkg::*;

    logic          enter;
    logic [W-1:0]  operand;
    logic          operand_ok;
    logic [1:0]    op;
    logic [RW-1:0] result;
    logic          done;
    logic          error;
    logic          busy;
    logic          clr_entry;
    logic [2:0]    state;

    modport master (
        output enter, operand, operand_ok, op,
        input  result, done, error, busy, clr_entry, state
    );

    modport slave (
        input  enter, operand, operand_ok, op,
        output result, done, error, busy, clr_entry, state
    );

endinterface

// File: rtl/calc_sequencer_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv : unsigned iterative shift-add multiplier (8 cycles) and, when
// the macro CALC_DIV_EN is defined, an unsigned restoring divider (8 cycles).
//   clk, reset : clock, synchronous active-high reset (aborts any operation)
//   start_i    : load operands and begin (mode_i: 0 = multiply, 1 = divide)
//   a_i, b_i   : magnitudes (multiplicand/multiplier or dividend/divisor)
//   busy_o     : iterating
//   done_o     : high in the final iteration cycle; prod_o/quot_o valid then
//   dbz_o      : divide started with a zero divisor (no iterations run)
//   prod_o     : 16-bit product, quot_o : 8-bit quotient (CALC_DIV_EN only)
// Results are presented combinationally in the last iteration so the caller
// can register them on the same edge that ends the iteration.
// -----------------------------------------------------------------------------
module seq_muldiv
    import calc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          dbz_o,
    output logic [RW-1:0] prod_o
`ifdef CALC_DIV_EN
    ,
    output logic [W-1:0]  quot_o
`endif
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    acc_q, acc_d;   // product accumulator / remainder
    logic [W-1:0]     x_q, x_d;       // multiplier bits / dividend->quotient
    logic [RW-1:0]    y_q, y_d;       // shifted multiplicand / divisor
    logic             start_ok_s;
    logic             last_s;
    logic [RW-1:0]    mul_acc_s;

`ifdef CALC_DIV_EN
    logic             mode_q, mode_d;
    logic             dbz_q, dbz_d;
    logic [W:0]       rem_sh_s;
    logic [W+1:0]     trial_s;
    logic [W:0]       div_rem_s;
    logic [W-1:0]     div_quo_s;

    assign start_ok_s = start_i;
`else
    // Without the divider a divide request is never accepted.
    assign start_ok_s = start_i & ~mode_i;
`endif

    assign mul_acc_s = x_q[0] ? (acc_q + y_q) : acc_q;
    assign last_s    = busy_q & (cnt_q == CNT_W'(ITER - 1));

`ifdef CALC_DIV_EN
    // One restoring-division step: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_sh_s = {acc_q[W-1:0], x_q[W-1]};
        trial_s  = {1'b0, rem_sh_s} - {2'b00, y_q[W-1:0]};
        if (trial_s[W+1]) begin
            div_rem_s = rem_sh_s;
            div_quo_s = {x_q[W-2:0], 1'b0};
        end else begin
            div_rem_s = trial_s[W:0];
            div_quo_s = {x_q[W-2:0], 1'b1};
        end
    end
`endif

    // Next-state logic for the iteration registers.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
`ifdef CALC_DIV_EN
        mode_d = mode_q;
        dbz_d  = dbz_q;
`endif
        if (start_ok_s) begin
            cnt_d = {CNT_W{1'b0}};
            acc_d = {RW{1'b0}};
`ifdef CALC_DIV_EN
            mode_d = mode_i;
            if (mode_i) begin
                x_d    = a_i;
                y_d    = {{(RW-W){1'b0}}, b_i};
                dbz_d  = (b_i == {W{1'b0}});
                busy_d = (b_i != {W{1'b0}});
            end else begin
                x_d    = b_i;
                y_d    = {{(RW-W){1'b0}}, a_i};
                dbz_d  = 1'b0;
                busy_d = 1'b1;
            end
`else
            x_d    = b_i;
            y_d    = {{(RW-W){1'b0}}, a_i};
            busy_d = 1'b1;
`endif
        end else if (busy_q) begin
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            busy_d = ~last_s;
`ifdef CALC_DIV_EN
            if (mode_q) begin
                acc_d = {{(RW-W-1){1'b0}}, div_rem_s};
                x_d   = div_quo_s;
                y_d   = y_q;
            end else begin
                acc_d = mul_acc_s;
                x_d   = {1'b0, x_q[W-1:1]};
                y_d   = {y_q[RW-2:0], 1'b0};
            end
`else
            acc_d = mul_acc_s;
            x_d   = {1'b0, x_q[W-1:1]};
            y_d   = {y_q[RW-2:0], 1'b0};
`endif
        end else begin
            busy_d = 1'b0;
        end
    end

    // Iteration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            acc_q  <= {RW{1'b0}};
            x_q    <= {W{1'b0}};
            y_q    <= {RW{1'b0}};
`ifdef CALC_DIV_EN
            mode_q <= 1'b0;
            dbz_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
`ifdef CALC_DIV_EN
            mode_q <= mode_d;
            dbz_q  <= dbz_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = last_s;
    assign prod_o = mul_acc_s;
`ifdef CALC_DIV_EN
    assign dbz_o  = dbz_q;
    assign quot_o = div_quo_s;
`else
    assign dbz_o  = 1'b0;
`endif

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer : captures operand A, then operand B plus operator, executes
// add / sub (1 cycle) or multiply (8 iterations); holds a signed 16-bit result.
// Optional macro CALC_DIV_EN adds signed division (op = 3); otherwise op = 3
// is reported as an error.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   bus       : calc_sequencer_if.slave
//     enter (rising edge acts), operand, operand_ok, op  -> inputs
//     result, done, error, busy, clr_entry, state        -> registered outputs
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    calc_sequencer_if.slave bus
);

    state_e        state_q, state_d;
    logic          enter_q;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    op_e           op_q, op_d;
    logic          sign_q, sign_d;
    logic [RW-1:0] result_q, result_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;
    logic          clr_q, clr_d;

    logic          edge_s;
    op_e           op_in_s;
    logic          md_kind_s;
    logic          md_start_s;
    logic          md_mode_s;
    logic [W-1:0]  md_a_s;
    logic [W-1:0]  md_b_s;
    logic          md_busy_s;
    logic          md_done_s;
    logic          md_dbz_s;
    logic [RW-1:0] md_prod_s;
`ifdef CALC_DIV_EN
    logic [W-1:0]  md_quot_s;
`endif

    // A held key produces a single edge because enter_q follows the level.
    assign edge_s  = bus.enter & ~enter_q;
    assign op_in_s = op_e'(bus.op);

`ifdef CALC_DIV_EN
    assign md_kind_s = (op_in_s == OP_MUL) || (op_in_s == OP_DIV);
`else
    assign md_kind_s = (op_in_s == OP_MUL);
`endif
    assign md_mode_s = (op_in_s == OP_DIV);
    // The iterative unit is loaded on the B-capture edge so its 8 cycles
    // coincide exactly with the 8 EXEC cycles.
    assign md_a_s    = mag(a_q);
    assign md_b_s    = mag(bus.operand);

    seq_muldiv u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start_s),
        .mode_i  (md_mode_s),
        .a_i     (md_a_s),
        .b_i     (md_b_s),
        .busy_o  (md_busy_s),
        .done_o  (md_done_s),
        .dbz_o   (md_dbz_s),
        .prod_o  (md_prod_s)
`ifdef CALC_DIV_EN
        ,
        .quot_o  (md_quot_s)
`endif
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; edges seen in EXEC are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A: begin
                if (edge_s) begin
                    if (bus.operand_ok) begin
                        state_d = ST_WAIT_B;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (edge_s) begin
                    if (bus.operand_ok) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: state_d = ST_DONE;
                    OP_MUL: begin
                        // An idle unit while still in EXEC means the operation
                        // can never finish; report it instead of hanging.
                        if (md_done_s) begin
                            state_d = ST_DONE;
                        end else if (!md_busy_s || md_dbz_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_DIV: begin
`ifdef CALC_DIV_EN
                        // Zero divisor leaves the unit idle with dbz set.
                        if (md_dbz_s) begin
                            state_d = ST_ERROR;
                        end else if (md_done_s) begin
                            state_d = ST_DONE;
                        end else if (!md_busy_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_EXEC;
                        end
`else
                        state_d = ST_ERROR;
`endif
                    end
                    default: state_d = ST_ERROR;
                endcase
            end
            ST_DONE, ST_ERROR: begin
                if (edge_s) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    // FSM output and datapath next-state logic.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sign_d     = sign_q;
        result_d   = result_q;
        clr_d      = 1'b0;
        md_start_s = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (edge_s && bus.operand_ok) begin
                    a_d   = bus.operand;
                    clr_d = 1'b1;
                end else begin
                    clr_d = 1'b0;
                end
            end
            ST_WAIT_B: begin
                if (edge_s && bus.operand_ok) begin
                    b_d        = bus.operand;
                    op_d       = op_in_s;
                    sign_d     = a_q[W-1] ^ bus.operand[W-1];
                    clr_d      = 1'b1;
                    md_start_s = md_kind_s;
                end else begin
                    clr_d = 1'b0;
                end
            end
            ST_EXEC: begin
                if (state_d == ST_DONE) begin
                    case (op_q)
                        OP_ADD:  result_d = sext(a_q) + sext(b_q);
                        OP_SUB:  result_d = sext(a_q) - sext(b_q);
                        OP_MUL:  result_d = apply_sign(sign_q, md_prod_s);
`ifdef CALC_DIV_EN
                        OP_DIV:  result_d = apply_sign(sign_q, {{(RW-W){1'b0}}, md_quot_s});
`else
                        OP_DIV:  result_d = result_q;
`endif
                        default: result_d = result_q;
                    endcase
                end else begin
                    result_d = result_q;
                end
            end
            ST_DONE, ST_ERROR: begin
                // Leaving a final state also clears the input-stage digits.
                if (edge_s) begin
                    clr_d = 1'b1;
                end else begin
                    clr_d = 1'b0;
                end
            end
            default: clr_d = 1'b0;
        endcase
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
        busy_d  = (state_d == ST_EXEC);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_q  <= 1'b0;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            op_q     <= OP_ADD;
            sign_q   <= 1'b0;
            result_q <= {RW{1'b0}};
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            enter_q  <= bus.enter;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            done_q   <= done_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            clr_q    <= clr_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.busy      = busy_q;
    assign bus.clr_entry = clr_q;
    assign bus.state     = state_q;

endmodule
